// File: rtl/imm_gen_stage_pkg.sv
// Shared types and opcode constants for the ID-stage immediate generator.
// Optional Zicsr immediate decoding is enabled by defining IMM_GEN_ZICSR_EN.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

  // I-type immediate pre-extended to 32 bits; reused by several opcodes.
  function automatic logic [31:0] imm_i32(logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / result-out handshake bundle for imm_gen_stage.
interface imm_gen_stage_if #(
  parameter int unsigned XLEN = 32
);
  import imm_gen_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic            out_illegal;

  // Upstream/downstream side that drives instructions and sinks results.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );

  // The stage itself.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decoder: format code, XLEN-wide immediate, illegal flag.
// Define IMM_GEN_ZICSR_EN to decode CSR*I uimm as FMT_Z.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // Every format fits a sign-extended 32-bit value; widen once at the end.
  logic [31:0] raw;

  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
        fmt = FMT_I;
        raw = imm_i32(instr);
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (instr[14]) begin
          fmt = FMT_Z;
          raw = {27'b0, instr[19:15]};
        end else begin
          fmt = FMT_I;
          raw = imm_i32(instr);
        end
`else
        fmt = FMT_I;
        raw = imm_i32(instr);
`endif
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt = FMT_I;
          raw = imm_i32(instr);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        illegal = 1'b0;
      end
      OPC_OP_32: begin
        illegal = (XLEN != 64);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // FMT_Z values are non-negative, so sign extension leaves them zero-extended.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered ID-stage immediate generator with a 2-entry skid buffer (output regs + skid).
// Define IMM_GEN_ZICSR_EN to enable FMT_Z decoding of CSR*I instructions.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          RESET_READY = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  imm_gen_stage_if.slave bus
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  logic            out_valid_q;
  logic [31:0]     out_instr_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] out_imm_q;
  imm_fmt_e        out_fmt_q;
  logic            out_illegal_q;

  logic            skid_valid_q;
  logic [31:0]     skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_imm_q;
  imm_fmt_e        skid_fmt_q;
  logic            skid_illegal_q;

  logic in_ready;
  logic accept;
  logic out_xfer;
  logic out_load;

  // Ready depends only on registered skid state (and reset), never on out_ready.
  assign in_ready = reset ? RESET_READY : ~skid_valid_q;
  assign accept   = bus.in_valid & in_ready;
  assign out_xfer = out_valid_q & bus.out_ready;
  assign out_load = ~out_valid_q | out_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        // Skid implies in_ready was low, so no new beat competes this cycle.
        out_valid_q   <= 1'b1;
        out_instr_q   <= skid_instr_q;
        out_pc_q      <= skid_pc_q;
        out_imm_q     <= skid_imm_q;
        out_fmt_q     <= skid_fmt_q;
        out_illegal_q <= skid_illegal_q;
        skid_valid_q  <= 1'b0;
      end else if (accept) begin
        out_valid_q   <= 1'b1;
        out_instr_q   <= bus.in_instr;
        out_pc_q      <= bus.in_pc;
        out_imm_q     <= dec_imm;
        out_fmt_q     <= dec_fmt;
        out_illegal_q <= dec_illegal;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q   <= 1'b1;
      skid_instr_q   <= bus.in_instr;
      skid_pc_q      <= bus.in_pc;
      skid_imm_q     <= dec_imm;
      skid_fmt_q     <= dec_fmt;
      skid_illegal_q <= dec_illegal;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench: RV32 and RV64 instances share stimulus and a queue-based reference model.
module tb_imm_gen_stage;

`ifdef IMM_GEN_ZICSR_EN
  localparam bit Zicsr = 1'b1;
`else
  localparam bit Zicsr = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush_t;
  logic        in_valid_t;
  logic [31:0] instr_t;
  logic [63:0] pc_t;
  logic        out_ready_t;

  imm_gen_stage_if #(.XLEN(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = in_valid_t;
  assign bus32.in_instr  = instr_t;
  assign bus32.in_pc     = pc_t[31:0];
  assign bus32.out_ready = out_ready_t;
  assign bus64.in_valid  = in_valid_t;
  assign bus64.in_instr  = instr_t;
  assign bus64.in_pc     = pc_t;
  assign bus64.out_ready = out_ready_t;

  imm_gen_stage #(.XLEN(32), .RESET_READY(1'b1)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .flush (flush_t),
    .bus   (bus32)
  );

  imm_gen_stage #(.XLEN(64), .RESET_READY(1'b0)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .flush (flush_t),
    .bus   (bus64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } beat_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic logic [63:0] sext(logic [63:0] v, int n);
    longint s;
    s = longint'(v << (64 - n));
    return s >>> (64 - n);
  endfunction

  function automatic dec_t ref_dec(logic [31:0] ins, bit rv64);
    dec_t r;
    r = '0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        r.fmt = 3'd1; r.imm = sext(64'(ins[31:20]), 12);
      end
      7'b1110011: begin
        if (Zicsr && ins[14]) begin
          r.fmt = 3'd6; r.imm = 64'(ins[19:15]);
        end else begin
          r.fmt = 3'd1; r.imm = sext(64'(ins[31:20]), 12);
        end
      end
      7'b0011011: begin
        if (rv64) begin
          r.fmt = 3'd1; r.imm = sext(64'(ins[31:20]), 12);
        end else r.ill = 1'b1;
      end
      7'b0100011: begin
        r.fmt = 3'd2; r.imm = sext(64'({ins[31:25], ins[11:7]}), 12);
      end
      7'b1100011: begin
        r.fmt = 3'd3;
        r.imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      end
      7'b0110111, 7'b0010111: begin
        r.fmt = 3'd4; r.imm = sext(64'({ins[31:12], 12'h000}), 32);
      end
      7'b1101111: begin
        r.fmt = 3'd5;
        r.imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      end
      7'b0110011: r.ill = 1'b0;
      7'b0111011: r.ill = !rv64;
      default:    r.ill = 1'b1;
    endcase
    if (!rv64) r.imm = {32'b0, r.imm[31:0]};
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_dut(string tag, bit rv64, bit rr, logic rdy, logic vld,
                           logic [31:0] ins, logic [63:0] pc, logic [63:0] imm,
                           logic [2:0] fmt, logic ill);
    dec_t        d;
    logic [63:0] epc;
    chk({tag, " in_ready"}, 64'(rdy), reset ? 64'(rr) : 64'(q.size() < 2));
    chk({tag, " out_valid"}, 64'(vld), 64'(q.size() > 0));
    if (reset) begin
      chk({tag, " rst instr"}, 64'(ins), 64'h0);
      chk({tag, " rst pc"}, pc, 64'h0);
      chk({tag, " rst imm"}, imm, 64'h0);
      chk({tag, " rst fmt"}, 64'(fmt), 64'h0);
      chk({tag, " rst illegal"}, 64'(ill), 64'h0);
    end else if (q.size() > 0) begin
      d   = ref_dec(q[0].instr, rv64);
      epc = rv64 ? q[0].pc : {32'b0, q[0].pc[31:0]};
      chk({tag, " instr"}, 64'(ins), 64'(q[0].instr));
      chk({tag, " pc"}, pc, epc);
      chk({tag, " imm"}, imm, d.imm);
      chk({tag, " fmt"}, 64'(fmt), 64'(d.fmt));
      chk({tag, " illegal"}, 64'(ill), 64'(d.ill));
    end
  endtask

  // Advance one edge: update the 2-deep queue model, then compare both DUTs.
  task automatic step();
    bit    acc;
    beat_t b;
    @(posedge clk);
    if (reset || flush_t) begin
      q.delete();
    end else begin
      acc = in_valid_t && (q.size() < 2);
      if (q.size() > 0 && out_ready_t) void'(q.pop_front());
      if (acc) begin
        b.instr = instr_t;
        b.pc    = pc_t;
        q.push_back(b);
      end
    end
    #1;
    check_dut("rv32", 1'b0, 1'b1, bus32.in_ready, bus32.out_valid, bus32.out_instr,
              {32'b0, bus32.out_pc}, {32'b0, bus32.out_imm}, bus32.out_fmt, bus32.out_illegal);
    check_dut("rv64", 1'b1, 1'b0, bus64.in_ready, bus64.out_valid, bus64.out_instr,
              bus64.out_pc, bus64.out_imm, bus64.out_fmt, bus64.out_illegal);
  endtask

  task automatic drive(bit v, logic [31:0] ins);
    in_valid_t = v;
    instr_t    = ins;
    pc_t       = {$urandom, $urandom};
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [13];
    logic [31:0] r;
    int          sel;
    opcs = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0011011, 7'b0110011,
             7'b0111011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011,
             7'b0001111};
    r   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 13) r[6:0] = opcs[sel];
    return r;
  endfunction

  initial begin
    reset       = 1'b1;
    flush_t     = 1'b0;
    out_ready_t = 1'b1;
    drive(1'b1, 32'h00000013);
    repeat (3) step();
    chk("rv64 ready in reset", 64'(bus64.in_ready), 64'h0);
    reset = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    chk("rv64 ready after reset", 64'(bus64.in_ready), 64'h1);

    drive(1'b1, 32'hFFF00093); step();
    chk("addi valid", 64'(bus32.out_valid), 64'h1);
    chk("addi imm32", 64'(bus32.out_imm), 64'hFFFFFFFF);
    chk("addi imm64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addi fmt", 64'(bus32.out_fmt), 64'd1);
    chk("addi illegal", 64'(bus32.out_illegal), 64'h0);
    drive(1'b1, 32'hFE112E23); step();
    chk("sw imm32", 64'(bus32.out_imm), 64'hFFFFFFFC);
    chk("sw fmt", 64'(bus32.out_fmt), 64'd2);
    drive(1'b1, 32'hFFDFF06F); step();
    chk("jal imm32", 64'(bus32.out_imm), 64'hFFFFFFFC);
    chk("jal fmt", 64'(bus32.out_fmt), 64'd5);
    drive(1'b1, 32'h800002B7); step();
    chk("lui imm64", bus64.out_imm, 64'hFFFFFFFF80000000);
    chk("lui imm32", 64'(bus32.out_imm), 64'h80000000);
    chk("lui fmt", 64'(bus64.out_fmt), 64'd4);
    drive(1'b1, 32'h0000001B); step();
    chk("opimm32 rv64 illegal", 64'(bus64.out_illegal), 64'h0);
    chk("opimm32 rv64 fmt", 64'(bus64.out_fmt), 64'd1);
    chk("opimm32 rv32 illegal", 64'(bus32.out_illegal), 64'h1);
    chk("opimm32 rv32 fmt", 64'(bus32.out_fmt), 64'd0);
    drive(1'b1, 32'h00000000); step();
    chk("zero illegal", 64'(bus32.out_illegal), 64'h1);
    chk("zero imm", bus64.out_imm, 64'h0);
    drive(1'b1, 32'h3400D073); step();
    chk("csrrwi fmt", 64'(bus32.out_fmt), Zicsr ? 64'd6 : 64'd1);
    chk("csrrwi imm", 64'(bus32.out_imm), Zicsr ? 64'h1 : 64'h340);
    drive(1'b0, 32'h0); step();

    // Back-pressure: A held, B in skid, C refused, then A and B drain in order.
    out_ready_t = 1'b0;
    drive(1'b1, 32'h00A00093); step();
    chk("bp A out", 64'(bus32.out_instr), 64'h00A00093);
    chk("bp ready1", 64'(bus32.in_ready), 64'h1);
    drive(1'b1, 32'h00B00113); step();
    chk("bp A held", 64'(bus32.out_instr), 64'h00A00093);
    chk("bp ready0", 64'(bus64.in_ready), 64'h0);
    drive(1'b1, 32'h00C00193); step();
    chk("bp A still", 64'(bus64.out_instr), 64'h00A00093);
    chk("bp ready still0", 64'(bus32.in_ready), 64'h0);
    out_ready_t = 1'b1;
    drive(1'b0, 32'h0); step();
    chk("bp B out", 64'(bus32.out_instr), 64'h00B00113);
    chk("bp ready back", 64'(bus32.in_ready), 64'h1);
    step();
    chk("bp drained", 64'(bus64.out_valid), 64'h0);

    // Flush with skid full and a beat offered in the same cycle.
    out_ready_t = 1'b0;
    drive(1'b1, 32'h00100093); step();
    drive(1'b1, 32'h00200093); step();
    flush_t = 1'b1;
    drive(1'b1, 32'h00300093); step();
    chk("flush valid", 64'(bus32.out_valid), 64'h0);
    chk("flush ready", 64'(bus64.in_ready), 64'h1);
    flush_t     = 1'b0;
    out_ready_t = 1'b1;
    drive(1'b0, 32'h0); step();
    chk("flush nothing left", 64'(bus32.out_valid), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      reset       = (i == 1500 || i == 1501);
      in_valid_t  = ($urandom_range(0, 9) < 7);
      instr_t     = rand_instr();
      pc_t        = {$urandom, $urandom};
      out_ready_t = ($urandom_range(0, 9) < 6);
      flush_t     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate generator for the ID stage of the RISC-V pipeline.
- Accepts one instruction plus PC per beat on a valid/ready handshake.
- Decodes the instruction format and produces an XLEN-wide sign/zero-extended immediate, a format code and an illegal flag.
- Presents results through a 2-entry skid buffer, so back-pressure from EX never drops an instruction.
- Supports RV32/RV64, pipeline flush and an illegal-opcode flag.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64 only.
RESET_READY, 1, value of in_ready while reset is asserted (0 or 1).

Ports:
clk  input  1  pipeline clock; one clock domain, all logic on the rising edge.
reset  input  1  reset; synchronous and active-high.
flush  input  1  discard all held and incoming instructions.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept this cycle.
in_instr  input  32  raw instruction.
in_pc  input  XLEN  instruction PC.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
out_instr  output  32  instruction passed through.
out_pc  output  XLEN  PC passed through.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  imm_fmt_e format code.
out_illegal  output  1  unsupported or illegal opcode.

Behaviour:
- Reset:
  - out_valid=0 and skid entry invalid.
  - out_instr, out_pc, out_imm = 0; out_fmt=FMT_NONE; out_illegal=0.
  - in_ready=RESET_READY during reset, 1 on the first cycle after.
- Latency: the result for an instruction accepted at edge N is valid after edge N (1 cycle). Throughput is 1 per cycle when out_ready=1.
- Handshake:
  - A transfer occurs when valid&&ready on the same edge.
  - in_ready = !skid_valid, a registered term with no combinational path from out_ready.
  - Output regs load when empty or when their content transfers.
  - If the output regs hold an untransferred beat and an input is accepted, the input is decoded into the skid entry.
  - The skid entry moves to the output regs on the next output transfer.
  - Order is always preserved.
  - Output fields are stable while out_valid&&!out_ready.
- Flush: on the next edge, out_valid and skid_valid are cleared, and any in_valid beat in the flush cycle is dropped. Flush has priority over acceptance. Reset has priority over flush.
- Decode, on in_instr[6:0]; sx() means sign-extend to XLEN from instr[31]:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011: FMT_I, sx(instr[31:20]).
  - OP-IMM-32 0011011: FMT_I, only when XLEN=64; illegal when XLEN=32.
  - STORE 0100011: FMT_S, sx({instr[31:25],instr[11:7]}).
  - BRANCH 1100011: FMT_B, sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - LUI 0110111, AUIPC 0010111: FMT_U, sx({instr[31:12],12'b0}); upper 32 bits are copies of instr[31] when XLEN=64.
  - JAL 1101111: FMT_J, sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - OP 0110011: FMT_NONE, imm 0, legal.
  - OP-32 0111011: FMT_NONE, imm 0, legal only when XLEN=64.
  - Anything else, including instr[1:0]!=2'b11: out_illegal=1, FMT_NONE, imm 0.
- Illegal beats still flow through the handshake; they are never dropped.

Optional Feature:
IMM_GEN_ZICSR_EN
- Defined: a SYSTEM opcode with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) yields FMT_Z with out_imm = zero-extended instr[19:15].
- Undefined: all SYSTEM instructions yield FMT_I per the table; FMT_Z is never produced.

Decomposition:
- Package imm_gen_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
  - Opcode localparams: OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM.
- Sub-module imm_decode_comb: purely combinational, instruction in; imm, fmt and illegal out. It is instantiated once and feeds both the output regs and the skid entry.

Test Plan:
- XLEN=32, out_ready=1: 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, FMT_I, out_illegal=0.
- 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, FMT_S; then 0xFFDFF06F (jal x0,-4) -> out_imm=0xFFFFFFFC, FMT_J.
- XLEN=64: 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, FMT_U; 0x0000001B (OP-IMM-32) is legal at XLEN=64 and illegal at XLEN=32.
- out_ready=0 for 3 cycles while feeding A then B back-to-back:
  - A is held on the outputs and B goes to the skid entry.
  - in_ready=0 until the first output transfer.
  - Outputs then show A, then B, with no loss.
- Skid full and flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed beats never appear.
- 0x00000000 -> out_illegal=1, out_imm=0. With IMM_GEN_ZICSR_EN defined, 0x3400D073 (csrrwi x0,mscratch,1) -> FMT_Z, out_imm=1; without it -> FMT_I, out_imm=0x340.
